mem_port_arbiter: RTL and testbench

//  Shares one Avalon-MM memory port between the CPU instruction fetch host (read-only)
//  and the data host (read/write). Sits between the core's fetch/data managers and a

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 99 +++++++++
 tb/tb_mem_port_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: instruction host, data host and memory-side Avalon-MM signals.
// The slave modport is the arbiter's view; master is the view of the hosts and memory around it.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0]   i_address;
    logic                i_read;
    logic [DATA_W-1:0]   i_readdata;
    logic                i_waitrequest;

    logic [ADDR_W-1:0]   d_address;
    logic                d_read;
    logic                d_write;
    logic [DATA_W-1:0]   d_writedata;
    logic [DATA_W/8-1:0] d_byteenable;
    logic [DATA_W-1:0]   d_readdata;
    logic                d_waitrequest;

    logic [ADDR_W-1:0]   m_address;
    logic                m_read;
    logic                m_write;
    logic [DATA_W-1:0]   m_writedata;
    logic [DATA_W/8-1:0] m_byteenable;
    logic [DATA_W-1:0]   m_readdata;
    logic                m_waitrequest;

    modport slave (
        input  i_address, i_read,
        output i_readdata, i_waitrequest,
        input  d_address, d_read, d_write, d_writedata, d_byteenable,
        output d_readdata, d_waitrequest,
        output m_address, m_read, m_write, m_writedata, m_byteenable,
        input  m_readdata, m_waitrequest
    );

    modport master (
        output i_address, i_read,
        input  i_readdata, i_waitrequest,
        output d_address, d_read, d_write, d_writedata, d_byteenable,
        input  d_readdata, d_waitrequest,
        input  m_address, m_read, m_write, m_writedata, m_byteenable,
        output m_readdata, m_waitrequest
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one Avalon-MM memory port between a read-only fetch host and a read/write data host.
// Registered fixed-priority grant with a starvation guard; non-pipelined waitrequest transfers.
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int DATA_PRIORITY = 1,
    parameter int MAX_CONSEC    = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
    output logic [1:0]          owner
);
    localparam int CW = $clog2(MAX_CONSEC + 1) < 1 ? 1 : $clog2(MAX_CONSEC + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       consec, consec_nxt;
    logic                i_req, d_req, prio_req, other_req, starved, prio_win, other_win;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] be;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            consec <= '0;
        end else begin
            state  <= state_nxt;
            consec <= consec_nxt;
        end
    end

    always_comb begin
        i_req     = bus.i_read;
        d_req     = bus.d_read | bus.d_write;
        prio_req  = (DATA_PRIORITY != 0) ? d_req : i_req;
        other_req = (DATA_PRIORITY != 0) ? i_req : d_req;
        starved   = (consec == CW'(MAX_CONSEC));
        // The priority host yields only when both request and it has used up its run.
        prio_win  = prio_req && !(other_req && starved);
        other_win = other_req && !prio_win;
    end

    always_comb begin
        state_nxt         = state;
        consec_nxt        = consec;
        addr              = '0;
        wdata             = '0;
        be                = '0;
        bus.m_read        = 1'b0;
        bus.m_write       = 1'b0;
        bus.i_waitrequest = 1'b1;
        bus.d_waitrequest = 1'b1;
        bus.i_readdata    = bus.m_readdata;
        bus.d_readdata    = bus.m_readdata;
        owner             = state;

        case (state)
            IDLE: begin
                if (prio_win) begin
                    state_nxt  = (DATA_PRIORITY != 0) ? OWN_D : OWN_I;
                    consec_nxt = !other_req ? '0 : (starved ? consec : consec + CW'(1));
                end else if (other_win) begin
                    state_nxt  = (DATA_PRIORITY != 0) ? OWN_I : OWN_D;
                    consec_nxt = '0;
                end
            end
            OWN_I: begin
                addr              = bus.i_address;
                be                = '1;
                bus.m_read        = bus.i_read;
                bus.i_waitrequest = bus.m_waitrequest;
                if (!bus.i_read || !bus.m_waitrequest)
                    state_nxt = IDLE;
            end
            OWN_D: begin
                addr              = bus.d_address;
                wdata             = bus.d_writedata;
                be                = bus.d_byteenable;
                bus.m_write       = bus.d_write;
                bus.m_read        = bus.d_read & ~bus.d_write;
                bus.d_waitrequest = bus.m_waitrequest;
                if (!d_req || !bus.m_waitrequest)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        bus.m_address    = addr;
        bus.m_writedata  = wdata;
        bus.m_byteenable = be;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, corner-case sequences, random vs model.
module tb_mem_port_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] owner0, owner1;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIORITY(1), .MAX_CONSEC(2)) dut0 (
        .clk(clk), .rst(rst), .bus(b0), .owner(owner0));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIORITY(0), .MAX_CONSEC(2)) dut1 (
        .clk(clk), .rst(rst), .bus(b1), .owner(owner1));

    typedef struct packed {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [3:0]  dbe;
        logic        mw;
        logic [31:0] mrd;
        logic [1:0]  eo;
        logic        emr;
        logic        emw;
        logic [31:0] ema;
        logic [31:0] emwd;
        logic [3:0]  embe;
        logic        eiw;
        logic        edw;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check0(input string tag, input logic [1:0] eo, input logic emr, input logic emw,
                          input logic [31:0] ema, input logic [31:0] emwd, input logic [3:0] embe,
                          input logic eiw, input logic edw, input logic [31:0] mrd);
        chk({tag, ".owner"}, 64'(owner0), 64'(eo));
        chk({tag, ".m_read"}, 64'(b0.m_read), 64'(emr));
        chk({tag, ".m_write"}, 64'(b0.m_write), 64'(emw));
        chk({tag, ".m_address"}, 64'(b0.m_address), 64'(ema));
        chk({tag, ".m_writedata"}, 64'(b0.m_writedata), 64'(emwd));
        chk({tag, ".m_byteenable"}, 64'(b0.m_byteenable), 64'(embe));
        chk({tag, ".i_waitrequest"}, 64'(b0.i_waitrequest), 64'(eiw));
        chk({tag, ".d_waitrequest"}, 64'(b0.d_waitrequest), 64'(edw));
        chk({tag, ".i_readdata"}, 64'(b0.i_readdata), 64'(mrd));
        chk({tag, ".d_readdata"}, 64'(b0.d_readdata), 64'(mrd));
    endtask

    task automatic idle_inputs();
        b0.i_read = 0; b0.i_address = '0; b0.d_read = 0; b0.d_write = 0;
        b0.d_address = '0; b0.d_writedata = '0; b0.d_byteenable = '0;
        b0.m_waitrequest = 0; b0.m_readdata = '0;
        b1.i_read = 0; b1.i_address = '0; b1.d_read = 0; b1.d_write = 0;
        b1.d_address = '0; b1.d_writedata = '0; b1.d_byteenable = '0;
        b1.m_waitrequest = 0; b1.m_readdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk); #1;
        check0("reset", 2'd0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'h0);
        chk("reset.owner1", 64'(owner1), 64'd0);
        rst = 1'b1;
    endtask

    // Reference model state: who owns the port and how many back-to-back priority grants.
    int          m_own, m_cons, win;
    logic        ir, dr, dw, mw;
    logic [31:0] ia, da, dwd, mrd;
    logic [3:0]  dbe;
    logic [1:0]  exp_order [6];

    initial begin
        tbl[0] = '{1, 32'h40, 0, 0, 32'h0,   32'h0,    4'h0, 0, 32'hDEADBEEF, 2'd0, 0, 0, 32'h0,   32'h0,    4'h0, 1, 1};
        tbl[1] = '{1, 32'h40, 0, 0, 32'h0,   32'h0,    4'h0, 0, 32'hDEADBEEF, 2'd1, 1, 0, 32'h40,  32'h0,    4'hF, 0, 1};
        tbl[2] = '{0, 32'h0,  0, 0, 32'h0,   32'h0,    4'h0, 0, 32'hDEADBEEF, 2'd0, 0, 0, 32'h0,   32'h0,    4'h0, 1, 1};
        tbl[3] = '{1, 32'h0,  0, 1, 32'h100, 32'h1234, 4'h3, 0, 32'hCAFEF00D, 2'd0, 0, 0, 32'h0,   32'h0,    4'h0, 1, 1};
        tbl[4] = '{1, 32'h0,  0, 1, 32'h100, 32'h1234, 4'h3, 0, 32'hCAFEF00D, 2'd2, 0, 1, 32'h100, 32'h1234, 4'h3, 1, 0};
        tbl[5] = '{1, 32'h0,  0, 0, 32'h100, 32'h1234, 4'h3, 0, 32'hCAFEF00D, 2'd0, 0, 0, 32'h0,   32'h0,    4'h0, 1, 1};
        tbl[6] = '{1, 32'h0,  0, 0, 32'h100, 32'h1234, 4'h3, 0, 32'hCAFEF00D, 2'd1, 1, 0, 32'h0,   32'h0,    4'hF, 0, 1};
        tbl[7] = '{0, 32'h0,  1, 1, 32'h200, 32'h55,   4'hC, 0, 32'h0BADF00D, 2'd0, 0, 0, 32'h0,   32'h0,    4'h0, 1, 1};
        tbl[8] = '{0, 32'h0,  1, 1, 32'h200, 32'h55,   4'hC, 0, 32'h0BADF00D, 2'd2, 0, 1, 32'h200, 32'h55,   4'hC, 1, 0};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            b0.i_read = tbl[i].ir; b0.i_address = tbl[i].ia;
            b0.d_read = tbl[i].dr; b0.d_write = tbl[i].dw; b0.d_address = tbl[i].da;
            b0.d_writedata = tbl[i].dwd; b0.d_byteenable = tbl[i].dbe;
            b0.m_waitrequest = tbl[i].mw; b0.m_readdata = tbl[i].mrd;
            #1;
            check0($sformatf("tbl%0d", i), tbl[i].eo, tbl[i].emr, tbl[i].emw, tbl[i].ema,
                   tbl[i].emwd, tbl[i].embe, tbl[i].eiw, tbl[i].edw, tbl[i].mrd);
        end

        // Starvation guard with MAX_CONSEC=2: both hosts hold their requests.
        do_reset();
        exp_order[0] = 2; exp_order[1] = 2; exp_order[2] = 1;
        exp_order[3] = 2; exp_order[4] = 2; exp_order[5] = 1;
        @(negedge clk);
        b0.i_read = 1; b0.d_read = 1;
        for (int k = 0; k < 6; k++) begin
            #1; chk($sformatf("starve.arb%0d", k), 64'(owner0), 64'd0);
            @(negedge clk); #1;
            chk($sformatf("starve.grant%0d", k), 64'(owner0), 64'(exp_order[k]));
            @(negedge clk);
        end

        // Slow memory holds the data transfer while the fetch waits.
        do_reset();
        @(negedge clk);
        b0.i_read = 1; b0.d_write = 1; b0.d_address = 32'h80; b0.m_waitrequest = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk($sformatf("slow.owner%0d", k), 64'(owner0), 64'd2);
            chk($sformatf("slow.iwait%0d", k), 64'(b0.i_waitrequest), 64'd1);
            chk($sformatf("slow.dwait%0d", k), 64'(b0.d_waitrequest), 64'd1);
        end
        @(negedge clk); b0.m_waitrequest = 0; #1;
        chk("slow.dwait_done", 64'(b0.d_waitrequest), 64'd0);
        chk("slow.iwait_done", 64'(b0.i_waitrequest), 64'd1);
        @(negedge clk); b0.d_write = 0; #1;
        chk("slow.idle", 64'(owner0), 64'd0);
        @(negedge clk); #1;
        chk("slow.then_i", 64'(owner0), 64'd1);
        chk("slow.i_done", 64'(b0.i_waitrequest), 64'd0);

        // Asynchronous reset in the middle of a stalled write.
        do_reset();
        @(negedge clk);
        b0.d_write = 1; b0.d_address = 32'hC0; b0.d_writedata = 32'hA5A5; b0.d_byteenable = 4'hF;
        b0.m_waitrequest = 1;
        @(negedge clk); #1;
        chk("rstmid.owner_before", 64'(owner0), 64'd2);
        chk("rstmid.write_before", 64'(b0.m_write), 64'd1);
        #2 rst = 1'b0; #1;
        chk("rstmid.write_async", 64'(b0.m_write), 64'd0);
        chk("rstmid.owner_async", 64'(owner0), 64'd0);
        @(negedge clk); rst = 1'b1; b0.m_waitrequest = 0; #1;
        chk("rstmid.idle", 64'(owner0), 64'd0);
        @(negedge clk); #1;
        check0("rstmid.redo", 2'd2, 0, 1, 32'hC0, 32'hA5A5, 4'hF, 1, 0, 32'h0);
        @(negedge clk); b0.d_write = 0;

        // Instruction priority instance.
        do_reset();
        @(negedge clk);
        b1.i_read = 1; b1.d_read = 1; b1.i_address = 32'h10; b1.d_address = 32'h20;
        #1; chk("iprio.arb", 64'(owner1), 64'd0);
        @(negedge clk); #1;
        chk("iprio.first", 64'(owner1), 64'd1);
        chk("iprio.addr_i", 64'(b1.m_address), 64'h10);
        chk("iprio.dwait", 64'(b1.d_waitrequest), 64'd1);
        @(negedge clk); b1.i_read = 0; #1;
        chk("iprio.idle", 64'(owner1), 64'd0);
        @(negedge clk); #1;
        chk("iprio.second", 64'(owner1), 64'd2);
        chk("iprio.addr_d", 64'(b1.m_address), 64'h20);
        chk("iprio.read_d", 64'(b1.m_read), 64'd1);

        // Random traffic against the reference model (data priority, MAX_CONSEC=2).
        do_reset();
        m_own = 0; m_cons = 0;
        ir = 0; dr = 0; dw = 0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) ir = 1'($urandom_range(1));
            if ($urandom_range(3) == 0) dr = 1'($urandom_range(1));
            if ($urandom_range(5) == 0) dw = 1'($urandom_range(1));
            mw = ($urandom_range(2) == 0);
            ia = $urandom; da = $urandom; dwd = $urandom; mrd = $urandom;
            dbe = 4'($urandom_range(15));
            b0.i_read = ir; b0.i_address = ia; b0.d_read = dr; b0.d_write = dw;
            b0.d_address = da; b0.d_writedata = dwd; b0.d_byteenable = dbe;
            b0.m_waitrequest = mw; b0.m_readdata = mrd;
            #1;
            if (m_own == 1)
                check0("rand", 2'd1, ir, 0, ia, 32'h0, 4'hF, mw, 1, mrd);
            else if (m_own == 2)
                check0("rand", 2'd2, dr && !dw, dw, da, dwd, dbe, 1, mw, mrd);
            else
                check0("rand", 2'd0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 1, mrd);

            if (m_own == 0) begin
                if ((dr || dw) && ir) win = (m_cons == 2) ? 1 : 2;
                else if (dr || dw)    win = 2;
                else if (ir)          win = 1;
                else                  win = 0;
                if (win == 2)      m_cons = ir ? ((m_cons < 2) ? m_cons + 1 : 2) : 0;
                else if (win == 1) m_cons = 0;
                m_own = win;
            end else if (((m_own == 1) ? !ir : !(dr || dw)) || !mw) begin
                m_own = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
